// File: rtl/spike_encoder.sv
// Rate-coding input stage: loads an N_IN-value frame over valid/ready, then
// emits deterministic accumulator-carry spike trains for WINDOW cycles and rests.
module spike_encoder #(
  parameter int N_IN     = 8,
  parameter int VAL_W    = 4,
  parameter int WINDOW   = 64,
  parameter int REST_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VAL_W-1:0]  data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              replay,
  input  logic              learn_en,
  output logic [0:N_IN-1]   spikes,
  output logic              learn,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WIN_W = $clog2(WINDOW);
  localparam int RST_W = (REST_LEN > 1) ? $clog2(REST_LEN) : 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_PRESENT,
    S_REST
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0] r_idx;
  logic [VAL_W-1:0] r_val [N_IN];
  logic [VAL_W-1:0] r_acc [N_IN];
  logic [VAL_W:0]   w_sum [N_IN];
  logic [WIN_W-1:0] r_win;
  logic [RST_W-1:0] r_rest;
  logic [0:N_IN-1]  r_spikes;
  logic             r_learn_lat;
  logic             r_learn;
  logic             r_done;

  logic w_accept;
  logic w_last_slot;
  logic w_start;
  logic w_win_end;
  logic w_rest_end;

  assign w_accept    = (r_state == S_LOAD) && data_valid;
  assign w_last_slot = (r_idx == IDX_W'(N_IN - 1));
  // data_valid outranks replay; replay only counts on an empty slot pointer
  assign w_start     = (r_state == S_LOAD) &&
                       ((data_valid && w_last_slot) ||
                        (!data_valid && replay && (r_idx == '0)));
  assign w_win_end   = (r_win == WIN_W'(WINDOW - 1));
  assign w_rest_end  = (r_rest == RST_W'(REST_LEN - 1));

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_val[i]};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:    if (w_start)    w_next = S_PRESENT;
      S_PRESENT: if (w_win_end)  w_next = S_REST;
      S_REST:    if (w_rest_end) w_next = S_LOAD;
      default:                   w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_win       <= '0;
      r_rest      <= '0;
      r_spikes    <= '0;
      r_learn_lat <= 1'b0;
      r_learn     <= 1'b0;
      r_done      <= 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        r_val[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_val[r_idx] <= data_in;
            r_idx        <= w_last_slot ? '0 : r_idx + 1'b1;
          end
          if (w_start) begin
            r_win       <= '0;
            r_spikes    <= '0;
            r_learn_lat <= learn_en;
            for (int unsigned i = 0; i < N_IN; i++) begin
              r_acc[i] <= '0;
            end
          end
        end
        S_PRESENT: begin
          for (int unsigned i = 0; i < N_IN; i++) begin
            r_acc[i]    <= w_sum[i][VAL_W-1:0];
            r_spikes[i] <= w_sum[i][VAL_W];
          end
          r_learn <= r_learn_lat;
          r_win   <= w_win_end ? '0 : r_win + 1'b1;
          r_rest  <= '0;
        end
        S_REST: begin
          r_spikes <= '0;
          r_learn  <= 1'b0;
          if (w_rest_end) begin
            r_rest <= '0;
            r_done <= 1'b1;
          end else begin
            r_rest <= r_rest + 1'b1;
          end
        end
        default: begin
          r_spikes <= '0;
          r_learn  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = (r_state == S_LOAD);
  assign busy       = (r_state != S_LOAD);
  assign spikes     = r_spikes;
  assign learn      = r_learn;
  assign done       = r_done;

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
Rate-coding input stage that sits directly upstream of the 8-synapse neuron. It accepts one frame of 8 intensity values over a valid/ready stream. It then presents the frame as 8 deterministic spike trains for a fixed window, followed by a silent rest period so the neuron membrane can leak back down. It also generates the neuron's learn strobe aligned to the presentation window.

Parameters:
N_IN, 8, number of spike channels; equals the neuron input width.
VAL_W, 4, intensity width; full scale is 2^VAL_W.
WINDOW, 64, presentation length in cycles; must be ≥2.
REST_LEN, 16, silent cycles after each presentation; must be ≥1.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
data_in  in  VAL_W  intensity for the current channel slot (unsigned).
data_valid  in  1  data_in is valid.
data_ready  out  1  encoder can accept a value; high only in LOAD.
replay  in  1  re-present the stored frame without reloading.
learn_en  in  1  sampled at frame start; enables the learn strobe for that frame.
spikes  out  [0:N_IN-1]  registered spike lines to the neuron inputs; bit i is channel i.
learn  out  1  registered learn strobe to the neuron.
busy  out  1  high whenever state ≠ LOAD.
done  out  1  registered one-cycle pulse at end of REST.

Behaviour:
- States: LOAD, PRESENT, REST.
- Reset values: state=LOAD, slot index idx=0, all stored values=0, all accumulators=0, counters=0, spikes=0, learn=0, done=0.
- Reset is honoured in any state; it aborts any presentation, and outputs are 0 (data_ready=1) in the cycle after the reset edge.
- LOAD:
  - data_ready=1. An accept occurs on data_valid&data_ready; data_in is stored to slot idx, and idx increments.
  - The accept of slot N_IN-1 causes idx←0 and a transition to PRESENT.
  - replay is honoured only when idx==0 and data_valid==0; it transitions to PRESENT with the stored values.
  - replay at idx≠0 is ignored. data_valid has priority over replay.
- Frame-start edge (the transition into PRESENT):
  - accumulators←0, window counter←0, spikes←0, learn_lat←learn_en.
- PRESENT, on every edge for each channel i:
  - {carry_i, acc_i} ← acc_i + val_i, computed at VAL_W+1 bits.
  - spikes[i] ← carry_i.
  - learn ← learn_lat. The window counter increments.
  - On the edge where the counter equals WINDOW-1, the state goes to REST. That edge still updates spikes and learn.
  - spikes and learn are therefore live for exactly WINDOW consecutive cycles.
  - Channel i emits exactly floor(WINDOW·val_i / 2^VAL_W) spikes per window. The first spike appears on output cycle ceil(2^VAL_W/val_i); val=0 never spikes.
- REST:
  - First edge: spikes←0, learn←0. The rest counter counts REST_LEN edges.
  - On the last REST edge: state←LOAD, done←1 for one cycle.
  - data_ready stays 0 until the cycle after that edge.
- data_valid while data_ready=0 is ignored; stored values are untouched.
- Stored values persist across frames until overwritten or reset.
- Counter widths are clog2(WINDOW) and clog2(REST_LEN); no wrap occurs because the terminal count transitions the state.
- Timeline: 8th accept at edge E0; spikes/learn live after E1..E64; REST edges E65..E80; done high during the cycle after E80; data_ready high from the cycle after E80.

Test Plan:
1. Load 0,1,2,4,8,12,15,15 with learn_en=1 → per-channel spike counts over the window are 0,4,8,16,32,48,60,60. learn is high exactly 64 cycles, coincident with the window. A single done pulse occurs 80 cycles after the 8th accept.
2. Channel with val=8 → spikes toggles 0,1,0,1… starting 0 on the first window cycle. val=15 → 0 on the first cycle, then 1 on 15 of every 16 cycles.
3. Hold data_valid=1 with changing data_in throughout PRESENT/REST → data_ready=0, no accepts. A following replay produces trains identical to the prior frame.
4. After done, pulse replay with learn_en=0 → identical spike trains, learn stays 0, no data accepts. Replay asserted together with data_valid → the data is accepted and replay is ignored.
5. Load 5 values, assert replay → ignored (busy stays 0). Load 3 more → presentation starts after the 8th accept using all 8 new values.
6. Assert reset at window cycle 20 → next cycle spikes=0, learn=0, busy=0, data_ready=1. An immediate replay produces an all-zero window (stored values cleared), followed by done after 80 cycles.
